// File: rtl/if_stage_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, reset PC and
// packed layouts of the branch and fetch-to-decode buses.
package if_stage_fetch_pkg;

  localparam int FS_TO_DS_BUS_WD = 64;
  localparam int BR_BUS_WD = 34;
  localparam logic [31:0] DEF_RESET_PC = 32'hbfc00000;

  // {br_stall[33], br_taken[32], br_target[31:0]}
  typedef struct packed {
    logic        stall;
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  // {inst[63:32], pc[31:0]}
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

  function automatic br_bus_t unpack_br(
    input logic [BR_BUS_WD-1:0] b
  );
    return br_bus_t'(b);
  endfunction

endpackage

// File: rtl/if_stage_fetch_if.sv
// Fetch-stage bus bundle: decode handshake, branch bus and
// instruction SRAM port. master = fetch stage, slave = environment.
interface if_stage_fetch_if;
  import if_stage_fetch_pkg::*;

  logic                       ds_allowin;
  logic [BR_BUS_WD-1:0]       br_bus;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       inst_sram_en;
  logic [3:0]                 inst_sram_wen;
  logic [31:0]                inst_sram_addr;
  logic [31:0]                inst_sram_wdata;
  logic [31:0]                inst_sram_rdata;

  modport master (
    input  ds_allowin,
    input  br_bus,
    input  inst_sram_rdata,
    output fs_to_ds_valid,
    output fs_to_ds_bus,
    output inst_sram_en,
    output inst_sram_wen,
    output inst_sram_addr,
    output inst_sram_wdata
  );

  modport slave (
    output ds_allowin,
    output br_bus,
    output inst_sram_rdata,
    input  fs_to_ds_valid,
    input  fs_to_ds_bus,
    input  inst_sram_en,
    input  inst_sram_wen,
    input  inst_sram_addr,
    input  inst_sram_wdata
  );

endinterface

// File: rtl/if_stage_fetch_buf.sv
// One-entry instruction buffer: captures SRAM data when IF stalls
// so the held word survives later SRAM output changes.
// Ports: clk, reset, fs_valid_i, ds_allowin_i, rdata_i, inst_o.
module if_stage_fetch_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        fs_valid_i,
  input  logic        ds_allowin_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] inst_o
);

  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;

  always_comb begin
    buf_valid_d = buf_valid_q;
    inst_buf_d  = inst_buf_q;
    if (fs_valid_i && ds_allowin_i) begin
      buf_valid_d = 1'b0;
    end else if (fs_valid_i && !buf_valid_q) begin
      // decode is stalled: capture the word before SRAM moves on
      buf_valid_d = 1'b1;
      inst_buf_d  = rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      inst_buf_q  <= 32'd0;
    end else begin
      buf_valid_q <= buf_valid_d;
      inst_buf_q  <= inst_buf_d;
    end
  end

  assign inst_o = buf_valid_q ? inst_buf_q : rdata_i;

endmodule

// File: rtl/if_stage_fetch.sv
// MIPS fetch stage: pre-IF PC generator plus IF register.
// Ports: clk, reset (sync, high), bus (master: decode/branch/SRAM).
module if_stage_fetch
  import if_stage_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  if_stage_fetch_if.master  bus
);

  br_bus_t   br;
  fs_to_ds_t fs_out;

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        br_pending_q, br_pending_d;
  logic [31:0] br_target_q, br_target_d;

  logic        to_fs_valid;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        sram_en;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;

  assign br          = unpack_br(bus.br_bus);
  assign to_fs_valid = ~reset;
  assign fs_ready_go = 1'b1;
  assign seq_pc      = fs_pc_q + 32'd4;
  assign fs_allowin  = ~fs_valid_q
                     | (fs_ready_go & bus.ds_allowin);
  assign sram_en     = to_fs_valid & fs_allowin
                     & ~br.stall;

  // a pending redirect outranks a fresh taken branch
  always_comb begin
    nextpc = seq_pc;
    unique case (1'b1)
      br_pending_q:
        nextpc = br_target_q;
      (!br_pending_q && br.taken && fs_valid_q):
        nextpc = br.target;
      default:
        nextpc = seq_pc;
    endcase
  end

  always_comb begin
    fs_valid_d = fs_valid_q;
    fs_pc_d    = fs_pc_q;
    if (sram_en) begin
      fs_valid_d = 1'b1;
      fs_pc_d    = nextpc;
    end else if (fs_allowin) begin
      fs_valid_d = 1'b0;
    end
  end

  // remember a taken branch whose target cannot be
  // requested now (no delay slot in IF, or no request)
  always_comb begin
    br_pending_d = br_pending_q;
    br_target_d  = br_target_q;
    if (sram_en && br_pending_q) begin
      br_pending_d = 1'b0;
    end else if (br.taken && !br_pending_q
                 && !(sram_en && fs_valid_q)) begin
      br_pending_d = 1'b1;
      br_target_d  = br.target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q   <= 1'b0;
      fs_pc_q      <= RESET_PC - 32'd4;
      br_pending_q <= 1'b0;
      br_target_q  <= 32'd0;
    end else begin
      fs_valid_q   <= fs_valid_d;
      fs_pc_q      <= fs_pc_d;
      br_pending_q <= br_pending_d;
      br_target_q  <= br_target_d;
    end
  end

  if_stage_fetch_buf u_buf (
    .clk         (clk),
    .reset       (reset),
    .fs_valid_i  (fs_valid_q),
    .ds_allowin_i(bus.ds_allowin),
    .rdata_i     (bus.inst_sram_rdata),
    .inst_o      (fs_inst)
  );

  assign fs_out = '{inst: fs_inst, pc: fs_pc_q};

  assign bus.fs_to_ds_valid  = fs_valid_q & fs_ready_go;
  assign bus.fs_to_ds_bus    = fs_out;
  assign bus.inst_sram_en    = sram_en;
  assign bus.inst_sram_wen   = 4'h0;
  assign bus.inst_sram_addr  = nextpc;
  assign bus.inst_sram_wdata = 32'd0;

endmodule
